// File: rtl/union_find.sv
// Disjoint-set engine: one parent pointer per element, FIND and UNION walked one pointer step per cycle.
// UNION links the larger root under the smaller one, so every chain strictly decreases and walks terminate.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a new (op, node1, node2) that differs from the last one
// S_WALK1  | following node1's chain to its root
// S_WALK2  | following node2's chain to its root (UNION only)
// S_LINK   | pointing the larger root at the smaller one
// S_FINISH | publishing result and raising done
module union_find #(
    parameter int N          = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            op,
    input  logic [ADDR_WIDTH-1:0] node1,
    input  logic [ADDR_WIDTH-1:0] node2,
    output logic [ADDR_WIDTH-1:0] result,
    output logic                  done
);

    localparam logic [1:0] OP_UNION = 2'b01;
    localparam logic [1:0] OP_FIND  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WALK1,
        S_WALK2,
        S_LINK,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0]     parent [N];
    logic [1:0]                op_q;
    logic [ADDR_WIDTH-1:0]     n2_q;
    logic [ADDR_WIDTH-1:0]     cur;
    logic [ADDR_WIDTH-1:0]     root1;
    logic [ADDR_WIDTH-1:0]     res;
    logic [2+2*ADDR_WIDTH-1:0] last_cmd;
    logic                      last_valid;

    logic                  launch;
    logic                  in_range;
    logic                  cur_is_root;
    logic [ADDR_WIDTH-1:0] parent_cur;
    logic [ADDR_WIDTH-1:0] link_lo;
    logic [ADDR_WIDTH-1:0] link_hi;

    function automatic logic valid_node(input logic [ADDR_WIDTH-1:0] n);
        return int'(n) < N;
    endfunction

    assign launch = (state == S_IDLE) && ((op == OP_UNION) || (op == OP_FIND)) &&
                    (!last_valid || ({op, node1, node2} != last_cmd));
    assign in_range    = valid_node(node1) && ((op == OP_FIND) || valid_node(node2));
    assign parent_cur  = parent[cur];
    assign cur_is_root = (parent_cur == cur);
    // In LINK, cur still holds root2 from the end of WALK2.
    assign link_lo     = (root1 < cur) ? root1 : cur;
    assign link_hi     = (root1 < cur) ? cur : root1;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (launch) state_nxt = in_range ? S_WALK1 : S_FINISH;
            S_WALK1:  if (cur_is_root) state_nxt = (op_q == OP_FIND) ? S_FINISH : S_WALK2;
            S_WALK2:  if (cur_is_root) state_nxt = S_LINK;
            S_LINK:   state_nxt = S_FINISH;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) parent[i] <= ADDR_WIDTH'(i);
            op_q       <= '0;
            n2_q       <= '0;
            cur        <= '0;
            root1      <= '0;
            res        <= '0;
            last_cmd   <= '0;
            last_valid <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        op_q       <= op;
                        n2_q       <= node2;
                        last_cmd   <= {op, node1, node2};
                        last_valid <= 1'b1;
                        done       <= 1'b0;
                        cur        <= node1;
                        // Out-of-range commands jump to FINISH and report node1.
                        res        <= node1;
                    end
                end
                S_WALK1: begin
                    if (cur_is_root) begin
                        root1 <= cur;
                        res   <= cur;
                        if (op_q == OP_UNION) cur <= n2_q;
                    end else begin
                        cur <= parent_cur;
                    end
                end
                S_WALK2: begin
                    if (!cur_is_root) cur <= parent_cur;
                end
                S_LINK: begin
                    if (root1 != cur) parent[link_hi] <= link_lo;
                    res <= link_lo;
                end
                S_FINISH: begin
                    result <= res;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_union_find.sv
// Bench for union_find: directed scenarios then random commands, checked against an array-based
// disjoint-set model that also predicts completion latency from tree depth.
module tb_union_find;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam logic [1:0] OP_UNION = 2'b01;
    localparam logic [1:0] OP_FIND  = 2'b10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [AW-1:0] node1 = '0;
    logic [AW-1:0] node2 = '0;
    logic [AW-1:0] result;
    logic          done;

    int checks = 0;
    int errors = 0;

    int       m_parent [N];
    int       m_result;
    int       m_done;
    bit       m_last_valid;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    union_find #(.N(N), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .node1 (node1),
        .node2 (node2),
        .result(result),
        .done  (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input int x, output int depth);
        depth = 0;
        while (m_parent[x] != x) begin
            x = m_parent[x];
            depth++;
        end
        return x;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_parent[i] = i;
        m_result     = 0;
        m_done       = 0;
        m_last_valid = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        op    = 2'b00;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_cmd(input logic [1:0] o, input int a, input int b, input string tag);
        logic [7:0] cmd;
        int r1, r2, d1, d2, exp_res, exp_lat, cnt;
        cmd = {o, AW'(a), AW'(b)};
        @(negedge clk);
        op    = o;
        node1 = AW'(a);
        node2 = AW'(b);
        if (m_last_valid && cmd == m_last) begin
            repeat (4) @(posedge clk);
            #1;
            check({tag, "_hold_done"}, 32'(done), 32'(m_done));
            check({tag, "_hold_result"}, 32'(result), 32'(m_result));
        end else begin
            r1 = m_find(a, d1);
            if (o == OP_FIND) begin
                exp_res = r1;
                exp_lat = d1 + 2;
            end else begin
                r2      = m_find(b, d2);
                exp_res = (r1 < r2) ? r1 : r2;
                if (r1 != r2) m_parent[(r1 > r2) ? r1 : r2] = exp_res;
                exp_lat = d1 + d2 + 4;
            end
            m_last       = cmd;
            m_last_valid = 1;
            @(posedge clk);
            #1;
            check({tag, "_launch_done"}, 32'(done), 0);
            // Scramble operands mid-command; they must be ignored.
            op    = 2'b00;
            node1 = AW'($urandom);
            node2 = AW'($urandom);
            cnt = 0;
            while (done !== 1'b1 && cnt < 100) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            check({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
            check({tag, "_result"}, 32'(result), 32'(exp_res));
            m_result = exp_res;
            m_done   = 1;
        end
    endtask

    task automatic do_noop(input logic [1:0] o, input int cycles);
        @(negedge clk);
        op    = o;
        node1 = AW'($urandom);
        node2 = AW'($urandom);
        repeat (cycles) @(posedge clk);
        #1;
        check("noop_done", 32'(done), 32'(m_done));
        check("noop_result", 32'(result), 32'(m_result));
    endtask

    initial begin
        int k, a, b;
        logic [1:0] o;
        model_reset();
        do_reset(2);

        for (int i = 0; i < N; i++) do_cmd(OP_FIND, i, 0, "find_init");

        do_cmd(OP_UNION, 1, 2, "u12");
        do_cmd(OP_UNION, 3, 4, "u34");
        do_cmd(OP_FIND, 1, 0, "f1");
        do_cmd(OP_FIND, 2, 0, "f2");
        do_cmd(OP_FIND, 3, 0, "f3");
        do_cmd(OP_FIND, 4, 0, "f4");

        do_cmd(OP_UNION, 5, 6, "u56");
        do_cmd(OP_UNION, 5, 1, "u51");
        do_cmd(OP_FIND, 5, 0, "f5");
        do_cmd(OP_FIND, 6, 0, "f6");
        do_cmd(OP_FIND, 3, 0, "f3b");
        do_cmd(OP_FIND, 4, 0, "f4b");

        do_cmd(OP_UNION, 2, 1, "u21");
        do_noop(2'b00, 10);
        do_noop(2'b11, 5);

        do_cmd(OP_FIND, 6, 0, "f6c");
        do_cmd(OP_FIND, 6, 0, "f6_repeat");
        do_cmd(OP_FIND, 4, 0, "f4c");

        // Abort a UNION walking a deep chain (6 -> 5 -> 1).
        @(negedge clk);
        op    = OP_UNION;
        node1 = 3'd6;
        node2 = 3'd4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        op    = 2'b00;
        @(posedge clk);
        #1;
        check("abort_done", 32'(done), 0);
        check("abort_result", 32'(result), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        do_cmd(OP_FIND, 2, 0, "abort_f2");
        for (int i = 0; i < N; i++) do_cmd(OP_FIND, i, 0, "abort_reinit");

        for (int it = 0; it < 120; it++) begin
            k = $urandom_range(9, 0);
            if (k == 0) begin
                do_noop(($urandom_range(1, 0) == 0) ? 2'b00 : 2'b11, $urandom_range(4, 1));
            end else if (k == 1 && m_last_valid) begin
                do_cmd(m_last[7:6], int'(m_last[5:3]), int'(m_last[2:0]), "rnd_repeat");
            end else begin
                o = ($urandom_range(9, 0) < 6) ? OP_UNION : OP_FIND;
                a = $urandom_range(N - 1, 0);
                b = $urandom_range(N - 1, 0);
                do_cmd(o, a, b, (o == OP_UNION) ? "rnd_union" : "rnd_find");
            end
        end

        do_reset(1);
        for (int i = 0; i < N; i++) do_cmd(OP_FIND, i, 0, "final_find");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
